// File: rtl/boot_sequencer_pkg.sv
// Shared types and constants for the boot-time image loader.
package boot_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_RUN,
        ST_ERR
    } boot_state_t;

    localparam int BOOT_LEN_BYTES = 2;

endpackage

// File: rtl/byte_packer.sv
// Four-lane byte register: assembles LSB-first bytes into a 32-bit word.
module byte_packer (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic        word_done,
    output logic [31:0] word
);

    logic [3:0][7:0] lanes;
    logic [3:0][7:0] merged;

    always_ff @(posedge clk) begin
        if (clr) begin
            byte_idx <= '0;
        end else if (load) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Lanes carry no reset: a word is only consumed once all four lanes are rewritten.
    always_ff @(posedge clk) begin
        if (load) begin
            lanes[byte_idx] <= byte_in;
        end
    end

    // Present the completed word in the same cycle the last byte arrives.
    always_comb begin
        merged = lanes;
        if (load) begin
            merged[byte_idx] = byte_in;
        end
    end

    assign word      = merged;
    assign word_done = load && (byte_idx == 2'd3);

endmodule

// File: rtl/boot_sequencer.sv
// Loads a length-prefixed byte stream into instruction memory, then releases the core.
module boot_sequencer
    import boot_sequencer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_WORDS = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IDX_W = $clog2(MAX_WORDS);
    localparam int LEN_W = 8 * BOOT_LEN_BYTES;

    boot_state_t      state, state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_rx;
    logic [IDX_W-1:0] word_idx;
    logic             fire;
    logic             len_bad;
    logic             last_word;
    logic             pk_load;
    logic             pk_clr;
    logic [1:0]       byte_idx;
    logic             word_done;
    logic [31:0]      word;

    assign rx_ready  = !rst && (state inside {ST_IDLE, ST_LEN_HI, ST_DATA});
    assign fire      = rx_valid && rx_ready;
    assign len_rx    = {rx_data, len[7:0]};
    assign len_bad   = (len_rx == '0) || (len_rx > LEN_W'(MAX_WORDS));
    assign last_word = (LEN_W'(word_idx) == (len - LEN_W'(1)));
    assign pk_load   = fire && (state == ST_DATA);
    assign pk_clr    = rst || (state == ST_IDLE);

    byte_packer u_packer (
        .clk       (clk),
        .clr       (pk_clr),
        .load      (pk_load),
        .byte_in   (rx_data),
        .byte_idx  (byte_idx),
        .word_done (word_done),
        .word      (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flash_en  = 1'b0;
        core_rst  = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fire) state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                busy = 1'b1;
                if (fire) state_nxt = len_bad ? ST_ERR : ST_DATA;
            end
            ST_DATA: begin
                busy = 1'b1;
                if (word_done) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                flash_en  = 1'b1;
                state_nxt = last_word ? ST_RUN : ST_DATA;
            end
            ST_RUN: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Flash port is captured with the 4th byte so it is stable for the whole WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            len        <= '0;
            word_idx   <= '0;
            flash_addr <= '0;
            flash_data <= '0;
        end else begin
            if (fire && (state == ST_IDLE)) begin
                len[7:0] <= rx_data;
            end
            if (fire && (state == ST_LEN_HI)) begin
                len[LEN_W-1:8] <= rx_data;
                word_idx       <= '0;
            end
            if ((state == ST_WRITE) && !last_word) begin
                word_idx <= word_idx + IDX_W'(1);
            end
            if (word_done) begin
                flash_addr <= WIDTH'({word_idx, 2'b00});
                flash_data <= WIDTH'(word);
            end
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: random streams and gaps against a stream-level model.
module tb_boot_sequencer;

    localparam int WIDTH     = 32;
    localparam int MAX_WORDS = 512;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [WIDTH-1:0] flash_addr;
    logic [WIDTH-1:0] flash_data;
    logic             flash_en;
    logic             core_rst;
    logic             busy;
    logic             done;
    logic             err;

    boot_sequencer #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t exp_q[$];
    int  due_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  pending_release = 1'b0;
    bit  prev_en = 1'b0;
    wr_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: derives the expected writes from the raw byte stream.
    function automatic bit model_load(input logic [7:0] s[$]);
        int count;
        int avail;
        bit bad;
        wr_t w;
        count = int'(s[0]) + 256 * int'(s[1]);
        bad   = (count == 0) || (count > MAX_WORDS);
        if (!bad) begin
            avail = (s.size() - 2) / 4;
            for (int i = 0; i < count && i < avail; i++) begin
                w.addr = 32'(4 * i);
                w.data = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
                w.last = (i == count - 1);
                exp_q.push_back(w);
            end
        end
        return bad;
    endfunction

    // Monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (pending_release) begin
            chk("release_done", 32'(done), 32'd1);
            chk("release_core_rst", 32'(core_rst), 32'd0);
            pending_release = 1'b0;
        end
        if (flash_en) begin
            chk("strobe_one_cycle", 32'(prev_en), 32'd0);
            chk("core_rst_during_write", 32'(core_rst), 32'd1);
            chk("rx_ready_during_write", 32'(rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", flash_addr, flash_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", flash_addr, mon_e.addr);
                chk("write_data", flash_data, mon_e.data);
                if (due_q.size() != 0) begin
                    chk("write_latency", 32'(cyc), 32'(due_q.pop_front()));
                end
                pending_release = mon_e.last;
            end
        end
        prev_en = flash_en;
    end

    // All driver tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
        bit acc;
        if (gaps) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: byte %h not accepted within 100 cycles", b);
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        bit bad;
        bit ok;
        bad = model_load(s);
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], gaps, ok);
            if (!ok) return;
            if (!bad && i >= 2 && ((i - 2) % 4 == 3)) due_q.push_back(cyc);
            if (bad && i == 1) begin
                chk("err_rise", 32'(err), 32'd1);
                chk("err_rx_ready", 32'(rx_ready), 32'd0);
            end
        end
    endtask

    task automatic check_run();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("run_done", 32'(done), 32'd1);
        chk("run_core_rst", 32'(core_rst), 32'd0);
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_err", 32'(err), 32'd0);
        chk("run_rx_ready", 32'(rx_ready), 32'd0);
        chk("run_writes_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic stall_check(input string name, input int n, input bit exp_err);
        rx_valid = 1'b1;
        for (int t = 0; t < n; t++) begin
            rx_data = 8'($urandom);
            @(negedge clk);
            chk({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_done"}, 32'(done), 32'(!exp_err));
        chk({name, "_core_rst"}, 32'(core_rst), 32'(exp_err));
    endtask

    task automatic do_reset();
        exp_q.delete();
        due_q.delete();
        pending_release = 1'b0;
        rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_flash_en", 32'(flash_en), 32'd0);
        chk("rst_flash_addr", flash_addr, 32'd0);
        chk("rst_flash_data", flash_data, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] nominal[$];
    logic [7:0] s[$];

    initial begin
        nominal = {8'h03, 8'h00, 8'h33, 8'h46, 8'hc6, 8'h00,
                   8'h13, 8'h06, 8'h16, 8'h00, 8'h6f, 8'hf0, 8'hdf, 8'hff};

        do_reset();
        send_stream(nominal, 1'b0);
        check_run();
        stall_check("post_run", 20, 1'b0);

        do_reset();
        send_stream(nominal, 1'b1);
        check_run();

        do_reset();
        s = {8'h00, 8'h00};
        send_stream(s, 1'b1);
        stall_check("zero_len", 5, 1'b1);

        do_reset();
        s = {8'h01, 8'h02};
        send_stream(s, 1'b0);
        stall_check("over_len", 5, 1'b1);

        do_reset();
        s = {8'h03, 8'h00, 8'h33, 8'h46, 8'hc6, 8'h00, 8'h13, 8'h06};
        send_stream(s, 1'b1);
        @(negedge clk);
        chk("midload_busy", 32'(busy), 32'd1);
        chk("midload_writes_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        s = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_stream(s, 1'b0);
        check_run();

        do_reset();
        s = {8'h00, 8'h02};
        for (int i = 0; i < 4 * MAX_WORDS; i++) s.push_back(8'($urandom));
        send_stream(s, 1'b0);
        check_run();

        for (int r = 0; r < 3; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 6);
            s = {8'(n), 8'h00};
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
            send_stream(s, 1'b1);
            check_run();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
